// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display
// Description : Multiplexed seven-segment scanner with a built-in refresh
//               divider, frame-synchronous (tear-free) data loading, per-digit
//               enable and decimal point, leading-zero blanking, a busy dash
//               mode and an anti-ghosting blank interval at the start of each
//               digit slot. All LED outputs are active-low.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               data_i           - 4*N_DIGITS hex nibbles, digit 0 rightmost
//               dp_i             - per-digit decimal point request (1 = lit)
//               digit_en_i       - per-digit enable (0 = dark)
//               load_i           - capture data_i/dp_i into pending register
//               blank_lz_i       - enable leading-zero blanking
//               busy_i           - show '-' on every enabled digit
//               led_en_o         - anode enables, one-hot-low when lit
//               seg_o            - cathodes {g,f,e,d,c,b,a}, active-low
//               dp_o             - decimal point cathode, active-low
//               frame_o          - one-cycle pulse after each frame wrap
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   data_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  input  logic [N_DIGITS-1:0]     digit_en_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic                    busy_i,
  output logic [N_DIGITS-1:0]     led_en_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] c_blank    = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]       c_seg_off  = 7'h7F;
  localparam logic [6:0]       c_seg_dash = 7'h3F;

  logic [DIV_W-1:0]      r_div_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_pend_data;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic [4*N_DIGITS-1:0] r_shadow_data;
  logic [N_DIGITS-1:0]   r_shadow_dp;

  logic                  w_div_tc;
  logic                  w_wrap;
  logic [N_DIGITS-1:0]   w_lz;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [3:0]            w_nib;
  logic                  w_sel_dp;
  logic                  w_sel_lz;
  logic                  w_sel_en;
  logic                  w_lit;
  logic                  w_zero_run;

  // Standard hex font, lowercase b and d, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign w_div_tc = (r_div_cnt == c_div_last);
  assign w_wrap   = w_div_tc && (r_idx == c_idx_last);

  // Leading-zero mask: walk from the most significant digit downwards while
  // every shadow nibble seen so far is zero. Digit 0 always stays visible,
  // and the dash mode overrides blanking.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_shadow_data[4*k +: 4] == 4'h0);
      w_lz[k]    = w_zero_run && (k != 0) && blank_lz_i && !busy_i;
    end
  end

  // Slot multiplexer written as a compare loop so non-power-of-two digit
  // counts never index past the vectors.
  always_comb begin
    w_onehot = '0;
    w_nib    = 4'h0;
    w_sel_dp = 1'b0;
    w_sel_lz = 1'b0;
    w_sel_en = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_nib       = r_shadow_data[4*k +: 4];
        w_sel_dp    = r_shadow_dp[k];
        w_sel_lz    = w_lz[k];
        w_sel_en    = digit_en_i[k];
      end
    end
  end

  // The first BLANK_CYC cycles of every slot keep all anodes off so the
  // previous digit's cathode pattern cannot ghost onto the next anode.
  assign w_lit = w_sel_en && (r_div_cnt >= c_blank) && !w_sel_lz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_idx         <= '0;
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      led_en_o      <= '1;
      seg_o         <= c_seg_off;
      dp_o          <= 1'b1;
      frame_o       <= 1'b0;
    end else begin
      if (w_div_tc) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      if (load_i) begin
        r_pend_data <= data_i;
        r_pend_dp   <= dp_i;
      end

      // Shadow only changes on the frame wrap; a load on that very edge
      // bypasses pending so it is not delayed by a whole frame.
      if (w_wrap) begin
        r_shadow_data <= load_i ? data_i : r_pend_data;
        r_shadow_dp   <= load_i ? dp_i   : r_pend_dp;
      end

      led_en_o <= w_lit ? ~w_onehot : '1;
      seg_o    <= !w_lit ? c_seg_off : (busy_i ? c_seg_dash : seg_decode(w_nib));
      dp_o     <= (w_lit && !busy_i) ? ~w_sel_dp : 1'b1;
      frame_o  <= w_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_display
// Description : Directed self-checking bench for seg7_scan_display with
//               N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1. Inputs change and
//               outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic [3:0]  digit_en_i;
  logic        load_i;
  logic        blank_lz_i;
  logic        busy_i;
  logic [3:0]  led_en_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_display #(
    .N_DIGITS  (4),
    .SCAN_DIV  (4),
    .BLANK_CYC (1)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .dp_i       (dp_i),
    .digit_en_i (digit_en_i),
    .load_i     (load_i),
    .blank_lz_i (blank_lz_i),
    .busy_i     (busy_i),
    .led_en_o   (led_en_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .frame_o    (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns on the falling edge where frame_o is seen high.
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_wait", {31'd0, seen}, 32'd1);
  endtask

  // Walks one whole frame (16 falling edges) starting right after a frame_o
  // edge. Cycle 0 of each slot is the blank interval; cycles 1..3 are lit
  // when the slot is marked lit. Optionally pulses load_i after step load_at.
  task automatic scan_frame(input string name, input logic [27:0] e_seg,
                            input logic [3:0] e_lit, input logic [3:0] e_dp,
                            input int load_at, input logic [15:0] ld_data,
                            input logic [3:0] ld_dp);
    logic       lit;
    logic [3:0] e_led;
    logic [6:0] e_s;
    logic       e_d;
    int         s;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        s     = 4*k + c;
        lit   = e_lit[k] && (c != 0);
        e_led = lit ? ~(4'b0001 << k) : 4'hF;
        e_s   = lit ? e_seg[7*k +: 7] : 7'h7F;
        e_d   = lit ? ~e_dp[k] : 1'b1;
        check($sformatf("%s led s%0d", name, s), {28'd0, led_en_o}, {28'd0, e_led});
        check($sformatf("%s seg s%0d", name, s), {25'd0, seg_o}, {25'd0, e_s});
        check($sformatf("%s dp s%0d", name, s), {31'd0, dp_o}, {31'd0, e_d});
        check($sformatf("%s frame s%0d", name, s), {31'd0, frame_o}, {31'd0, (s == 15)});
        if (s == load_at) begin
          load_i = 1'b1;
          data_i = ld_data;
          dp_i   = ld_dp;
        end else begin
          load_i = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    data_i     = 16'h0;
    dp_i       = 4'h0;
    digit_en_i = 4'hF;
    load_i     = 1'b0;
    blank_lz_i = 1'b0;
    busy_i     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst led", {28'd0, led_en_o}, 32'hF);
    check("rst seg", {25'd0, seg_o}, 32'h7F);
    check("rst dp", {31'd0, dp_o}, 32'd1);
    check("rst frame", {31'd0, frame_o}, 32'd0);

    // First frame: load 12AF with the decimal point on digit 2.
    rst_n  = 1'b1;
    load_i = 1'b1;
    data_i = 16'h12AF;
    dp_i   = 4'b0100;
    @(negedge clk);
    load_i = 1'b0;
    wait_frame();
    // Slots F,A,2,1; queue 1111 early in this frame (must not show yet).
    scan_frame("hex", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'b0100, 2, 16'h1111, 4'h0);
    // All 1s; load 2222 in the middle of slot 1 -> not visible this frame.
    scan_frame("tear", {7'h79, 7'h79, 7'h79, 7'h79}, 4'hF, 4'h0, 5, 16'h2222, 4'h0);
    // All 2s; load 5555 exactly on the wrap edge.
    scan_frame("twos", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'h0, 14, 16'h5555, 4'h0);
    blank_lz_i = 1'b1;
    // All 5s (no zeros, blanking has no effect); queue 0030.
    scan_frame("wrapld", {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF, 4'h0, 2, 16'h0030, 4'h0);
    // Digits 3,2 blanked; digit 1 shows 3, digit 0 shows 0. Queue 0000.
    scan_frame("lz30", {7'h00, 7'h00, 7'h30, 7'h40}, 4'b0011, 4'h0, 2, 16'h0000, 4'h0);
    // Only digit 0 lit.
    scan_frame("lz00", {7'h00, 7'h00, 7'h00, 7'h40}, 4'b0001, 4'h0, -1, 16'h0000, 4'h0);
    busy_i     = 1'b1;
    digit_en_i = 4'b1010;
    // Dashes on slots 1 and 3, blanking ignored, dp suppressed. Queue 8888.
    scan_frame("busy", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1010, 4'h0, 2, 16'h8888, 4'hF);

    // Outputs are lit (slot 3 dash) here; reset between edges must darken them.
    #1 rst_n = 1'b0;
    #1;
    check("arst led", {28'd0, led_en_o}, 32'hF);
    check("arst seg", {25'd0, seg_o}, 32'h7F);
    check("arst dp", {31'd0, dp_o}, 32'd1);
    check("arst frame", {31'd0, frame_o}, 32'd0);
    busy_i     = 1'b0;
    blank_lz_i = 1'b0;
    digit_en_i = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel blank led", {28'd0, led_en_o}, 32'hF);
    @(negedge clk);
    check("rel lit led", {28'd0, led_en_o}, 32'hE);
    check("rel lit seg", {25'd0, seg_o}, 32'h40);
    // Pending was cleared too, so the next frame still shows zeros.
    wait_frame();
    scan_frame("postrst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, -1, 16'h0000, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised multiplexed seven-segment scanner that replaces the fixed 8-digit display path fed by the CPU debug register. It has a built-in refresh divider, a configurable digit count, and tear-free frame-synchronous data loading. It also supports per-digit enable and decimal-point control, leading-zero blanking, a busy "dash" mode, and an anti-ghosting blank interval. It sits between the CPU debug output and the board LED pins; all LED outputs are active-low.

## Interface
- N_DIGITS, 8, number of multiplexed digits (1..16)
- SCAN_DIV, 100000, clk cycles per digit slot (≥ 2)
- BLANK_CYC, 16, cycles at start of each slot with all anodes off (0 ≤ BLANK_CYC < SCAN_DIV)
- clk  input  1  system clock; the block has one clock
- rst_n  input  1  asynchronous active-low reset
- data_i  input  4*N_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 is rightmost
- dp_i  input  N_DIGITS  decimal point request per digit, 1 = lit
- digit_en_i  input  N_DIGITS  per-digit enable, 0 = digit dark
- load_i  input  1  capture data_i/dp_i into the pending register
- blank_lz_i  input  1  enable leading-zero blanking
- busy_i  input  1  show '-' on every enabled digit
- led_en_o  output  N_DIGITS  anode enables, active-low, one-hot-low when lit
- seg_o  output  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp_o  output  1  decimal point cathode, active-low
- frame_o  output  1  one-cycle pulse at each frame wrap

## Operation
- Reset (async, rst_n=0): div_cnt=0, idx=0, pending=0, shadow=0; led_en_o all 1, seg_o=7'h7F, dp_o=1, frame_o=0.
- Divider: div_cnt counts 0..SCAN_DIV-1. At terminal count it returns to 0 and idx increments. idx wraps from N_DIGITS-1 to 0; that wrap is the frame wrap.
- Loading: load_i=1 writes data_i/dp_i into pending. On each frame wrap, shadow ← pending. If load_i and the wrap coincide, shadow takes data_i/dp_i directly. Displayed data therefore never changes mid-frame.
- Digit k is lit in slot idx=k only when all of the following hold: digit_en_i[k]=1, div_cnt ≥ BLANK_CYC, and k is not blanked as a leading zero.
- Leading-zero blanking: when blank_lz_i=1 and busy_i=0, digit k is blanked if shadow nibbles N_DIGITS-1 down to k are all 0. Digit 0 is never blanked. The rule is evaluated on shadow, not data_i.
- Segment decode uses the standard hex font with lowercase b and d. Active-low examples: 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E.
- busy_i=1: every enabled digit shows '-' (7'h3F) with dp_o=1. Leading-zero blanking is ignored while busy.
- Dark slot: led_en_o all 1, seg_o=7'h7F, dp_o=1.
- dp_o=~shadow_dp[idx] when the digit is lit and busy_i=0.

## Timing
- All outputs are registered. The outputs in cycle t+1 reflect div_cnt, idx, shadow and the control inputs sampled at edge t.
- frame_o is high for exactly one cycle: the cycle after the edge on which idx wraps to 0.
- Slot length is exactly SCAN_DIV cycles. Frame length is N_DIGITS*SCAN_DIV cycles. Lit time per slot is SCAN_DIV-BLANK_CYC cycles.
- Load-to-display latency runs from the load edge to the next frame wrap plus 1 cycle, up to N_DIGITS*SCAN_DIV+1 cycles.
- digit_en_i, blank_lz_i and busy_i are unlatched and take effect one cycle after sampling, even mid-slot.
- When rst_n deasserts mid-frame, scanning restarts at idx=0, div_cnt=0 with blank shadow.
- A reset asserted mid-frame forces all outputs dark immediately, without waiting for a clock edge.

## Test plan
- N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1; load data_i=16'h12AF, dp_i=4'b0100, all enabled.
  - After first frame_o: slots show F,A,2,1, i.e. seg_o = 7'h0E, 7'h08, 7'h24, 7'h79.
  - led_en_o per slot: 1110, 1101, 1011, 0111, each lit 3 of 4 cycles.
  - dp_o=0 only in slot 2.
- Tear-free load: load 16'h1111, then load 16'h2222 in the middle of slot 1. Remaining slots still show 1. The first 2 appears in slot 0 of the next frame.
- Leading-zero blanking: blank_lz_i=1, data 16'h0030. Digits 3 and 2 are dark; digit 1 shows 3 (7'h30); digit 0 shows 0 (7'h40). Data 16'h0000 leaves only digit 0 lit.
- busy_i=1 with digit_en_i=4'b1010: slots 1 and 3 show 7'h3F with dp_o=1; slots 0 and 2 are dark.
- Async reset asserted between clock edges mid-slot: led_en_o=4'hF, seg_o=7'h7F, frame_o=0 immediately. After release, the first lit slot is idx 0 showing 0, with the previous shadow cleared.
- Load coincident with wrap: pulse load_i on the wrap edge with 16'h5555. Slot 0 of the new frame shows 5 (7'h12).
